// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver that shares the uart transmitter's baud_set table.
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames with a parity_err strobe (8N1 otherwise).
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] baud_set,
    input  logic       rs232_rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    // The slowest rate has the largest divider, so it sizes the counter.
    localparam int DIV_MAX = (CLK_FREQ + 8 * 9600) / (16 * 9600);
    localparam int CNT_W   = $clog2(DIV_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    function automatic int baud_of(input int idx);
        case (idx)
            1:       return 19200;
            2:       return 38400;
            3:       return 57600;
            4:       return 115200;
            default: return 9600;
        endcase
    endfunction

    logic [CNT_W-1:0] div_tab [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_div
        localparam int BAUD = baud_of(gi);
        localparam int DIV  = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
        assign div_tab[gi] = CNT_W'(DIV);
    end

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, rx_d_q;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       baud_idx_q, baud_idx_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       samp_q, samp_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             rx_done_q, rx_done_d;
    logic             frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic             parity_bad_q, parity_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    logic             start_det;
    logic [2:0]       baud_sel;
    logic [CNT_W-1:0] div_last;
    logic             tick;
    logic             decide;
    logic             last_tick;
    logic             maj;

    always_comb begin
        baud_sel  = (baud_set > 4'd4) ? 3'd0 : baud_set[2:0];
        start_det = (state_q == S_IDLE) && !sync2_q && rx_d_q;
        div_last  = div_tab[baud_idx_q] - CNT_W'(1);
        tick      = (div_cnt_q == div_last);
        decide    = tick && (tick_cnt_q == 4'd9);
        last_tick = tick && (tick_cnt_q == 4'd15);
        // Samples from ticks 7 and 8 plus the live line value at tick 9.
        maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);
        // Clearing on the start edge puts every bit's sample window at mid-bit.
        div_cnt_d = (start_det || tick) ? '0 : div_cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        baud_idx_d   = baud_idx_q;
        tick_cnt_d   = tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        data_d       = data_q;
        rx_done_d    = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
        parity_err_d = 1'b0;
`endif

        if (state_q != S_IDLE && tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            if (tick_cnt_q == 4'd7 || tick_cnt_q == 4'd8) begin
                samp_d = {samp_q[0], sync2_q};
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_det) begin
                    state_d    = S_START;
                    baud_idx_d = baud_sel;
                    tick_cnt_d = 4'd0;
                    bit_idx_d  = 3'd0;
                end
            end
            S_START: begin
                if (decide && maj) begin
                    state_d = S_IDLE;
                end else if (last_tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[7:1]};
                end
                if (last_tick) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (decide) begin
                    parity_bad_d = (maj != ^shift_q);
                end
                if (last_tick) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-stop so a start edge in the second half is not missed.
                if (decide) begin
                    state_d = S_IDLE;
                    if (!maj) begin
                        frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (parity_bad_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else begin
                        rx_done_d = 1'b1;
                        data_d    = shift_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_d_q       <= 1'b1;
            div_cnt_q    <= '0;
            baud_idx_q   <= 3'd0;
            tick_cnt_q   <= 4'd0;
            bit_idx_q    <= 3'd0;
            samp_q       <= 2'b11;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= rs232_rx;
            sync2_q      <= sync1_q;
            rx_d_q       <= sync2_q;
            div_cnt_q    <= div_cnt_d;
            baud_idx_q   <= baud_idx_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_byte  = data_q;
    assign rx_done    = rx_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven at the receiver's own bit period,
// strobes counted on the falling clock edge and compared against hand-computed values.
module tb_uart_rx;

    // 7.3728 MHz gives dividers 48, 24, 12, 8, 4 for baud_set 0..4.
    localparam int CLK_FREQ = 7_372_800;
    localparam int DIV_TAB [5] = '{48, 24, 12, 8, 4};
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] baud_set;
    logic       rs232_rx;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;
    int n_done  = 0;
    int n_ferr  = 0;
    int n_perr  = 0;
    logic [7:0] rx_log [64];
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_set   (baud_set),
        .rs232_rx   (rs232_rx),
        .data_byte  (data_byte),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    // Each strobe cycle is counted, so a strobe longer than one clock shows up as an extra count.
    always @(negedge clk) begin
        if (rx_done) begin
            rx_log[n_done % 64] = data_byte;
            n_done++;
        end
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input int div, input logic pulse_rst);
        rs232_rx = v;
        if (pulse_rst) begin
            repeat (8 * div) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            repeat (8 * div - 1) @(negedge clk);
        end else begin
            repeat (16 * div) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int div, input logic stop_bit,
                              input int rst_bit, input int baud_after_start);
        $display("frame data=0x%02h div=%0d stop=%0b rst_bit=%0d", b, div, stop_bit, rst_bit);
        drive_bit(1'b0, div, 1'b0);
        if (baud_after_start >= 0) baud_set = 4'(baud_after_start);
        for (int i = 0; i < 8; i++) drive_bit(b[i], div, (i == rst_bit));
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip, div, 1'b0);
`endif
        drive_bit(stop_bit, div, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, f0, p0;
        rst      = 1'b1;
        rs232_rx = 1'b1;
        baud_set = 4'd4;
        repeat (3) @(negedge clk);
        chk("rst_data",  data_byte, 32'h00);
        chk("rst_done",  rx_done, 0);
        chk("rst_ferr",  frame_err, 0);
        chk("rst_perr",  parity_err, 0);
        chk("rst_busy",  busy, 0);
        rst = 1'b0;
        idle_clks(8);

        // 0x55 at 115200
        d0 = n_done; f0 = n_ferr;
        send_frame(8'h55, DIV_TAB[4], 1'b1, -1, -1);
        chk("t1_done", n_done - d0, 1);
        chk("t1_data", data_byte, 8'h55);
        chk("t1_busy", busy, 0);
        chk("t1_ferr", n_ferr - f0, 0);

        // Back-to-back frames at 9600 with a single stop bit between them
        baud_set = 4'd0;
        idle_clks(32);
        d0 = n_done; f0 = n_ferr;
        send_frame(8'hA3, DIV_TAB[0], 1'b1, -1, -1);
        send_frame(8'h0F, DIV_TAB[0], 1'b1, -1, -1);
        chk("t2_done",  n_done - d0, 2);
        chk("t2_byte0", rx_log[d0 % 64], 8'hA3);
        chk("t2_byte1", rx_log[(d0 + 1) % 64], 8'h0F);
        chk("t2_ferr",  n_ferr - f0, 0);

        // Bad stop bit, then a long break, then a clean frame
        baud_set = 4'd3;
        idle_clks(32);
        d0 = n_done; f0 = n_ferr;
        send_frame(8'h3C, DIV_TAB[3], 1'b0, -1, -1);
        chk("t3_ferr", n_ferr - f0, 1);
        chk("t3_done", n_done - d0, 0);
        chk("t3_hold", data_byte, 8'h0F);
        idle_clks(3 * FRAME_BITS * 16 * DIV_TAB[3]);
        chk("t3_break_ferr", n_ferr - f0, 1);
        chk("t3_break_busy", busy, 0);
        rs232_rx = 1'b1;
        idle_clks(2 * 16 * DIV_TAB[3]);
        d0 = n_done;
        send_frame(8'h81, DIV_TAB[3], 1'b1, -1, -1);
        chk("t3_done81", n_done - d0, 1);
        chk("t3_data81", data_byte, 8'h81);

        // Three-tick low glitch on an idle line is a false start
        baud_set = 4'd4;
        idle_clks(32);
        d0 = n_done; f0 = n_ferr;
        rs232_rx = 1'b0;
        idle_clks(3 * DIV_TAB[4]);
        chk("t4_busy_hi", busy, 1);
        rs232_rx = 1'b1;
        idle_clks(7 * DIV_TAB[4] + 6);
        chk("t4_busy_lo", busy, 0);
        idle_clks(32 * DIV_TAB[4]);
        chk("t4_done", n_done - d0, 0);
        chk("t4_ferr", n_ferr - f0, 0);

        // Reset pulse in bit 4 aborts the frame (bits 4..7 high so the line stays idle)
        baud_set = 4'd2;
        idle_clks(32);
        d0 = n_done; f0 = n_ferr;
        send_frame(8'hF5, DIV_TAB[2], 1'b1, 4, -1);
        chk("t5_done", n_done - d0, 0);
        chk("t5_ferr", n_ferr - f0, 0);
        chk("t5_data", data_byte, 8'h00);
        idle_clks(32);
        send_frame(8'hE7, DIV_TAB[2], 1'b1, -1, -1);
        chk("t5_doneE7", n_done - d0, 1);
        chk("t5_dataE7", data_byte, 8'hE7);

        // Out-of-range baud_set selects 9600; a mid-frame change is ignored
        baud_set = 4'd9;
        idle_clks(32);
        d0 = n_done;
        send_frame(8'h5A, DIV_TAB[0], 1'b1, -1, 4);
        chk("t6_done", n_done - d0, 1);
        chk("t6_data", data_byte, 8'h5A);

`ifdef UART_RX_PARITY_EN
        baud_set = 4'd4;
        idle_clks(32);
        d0 = n_done; f0 = n_ferr; p0 = n_perr;
        par_flip = 1'b0;
        send_frame(8'h07, DIV_TAB[4], 1'b1, -1, -1);
        chk("t7_done", n_done - d0, 1);
        chk("t7_data", data_byte, 8'h07);
        par_flip = 1'b1;
        idle_clks(32);
        send_frame(8'h07, DIV_TAB[4], 1'b1, -1, -1);
        chk("t7_perr",  n_perr - p0, 1);
        chk("t7_done2", n_done - d0, 1);
        chk("t7_hold",  data_byte, 8'h07);
        idle_clks(32);
        send_frame(8'h07, DIV_TAB[4], 1'b0, -1, -1);
        chk("t7_ferr",  n_ferr - f0, 1);
        chk("t7_perr2", n_perr - p0, 1);
        par_flip = 1'b0;
        rs232_rx = 1'b1;
        idle_clks(32);
`else
        p0 = n_perr;
        chk("no_perr", p0, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
